// File: rtl/snail_1101_tdm_sched.sv
// -----------------------------------------------------------------------------
// snail_1101_tdm_sched
//   Time-division scheduler that shares one overlapping "1101" Moore detector
//   across NCH serial bit channels. Each channel owns a 1-deep holding register
//   (pend/hbit) and a saved detector state (ctx). A round-robin arbiter grants one
//   pending channel per cycle. The shared next-state function runs on that
//   channel's context, and the result is written back.
//
//   Ports
//     clk          in   1     clock, rising edge
//     reset        in   1     asynchronous, active-high reset
//     bit_valid    in   NCH   per-channel input bit valid
//     bit_data     in   NCH   per-channel input bit
//     bit_ready    out  NCH   per-channel accept (valid & ready transfers)
//     match_valid  out  1     registered 1-cycle pulse: granted channel reached S4
//     match_ch     out  CHW   channel of the last match (held between matches)
//     cnt_sel      in   CHW   match counter read select
//     cnt_val      out  CNTW  match count of channel cnt_sel
//
//   Build option
//     SNAIL_MATCH_CNT_EN : when defined, per-channel saturating match counters
//                          are built and read through cnt_sel/cnt_val. When it is
//                          undefined, cnt_val is tied to zero.
// -----------------------------------------------------------------------------
module snail_1101_tdm_sched #(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  bit_valid,
    input  logic [NCH-1:0]  bit_data,
    output logic [NCH-1:0]  bit_ready,
    output logic            match_valid,
    output logic [CHW-1:0]  match_ch,
    input  logic [CHW-1:0]  cnt_sel,
    output logic [CNTW-1:0] cnt_val
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t         ctx_r [NCH];
    logic [NCH-1:0] pend_r;
    logic [NCH-1:0] hbit_r;
    logic [CHW-1:0] rr_ptr_r;

    logic [NCH-1:0] gnt_s;
    logic           gnt_any_s;
    logic [CHW-1:0] gnt_idx_s;
    logic [CHW-1:0] rr_next_s;
    logic [NCH-1:0] accept_s;
    state_t         next_s;
    logic           hit_s;

    // Overlapping 1101 detector. Unused codes recover to S0.
    function automatic state_t next_state(input state_t cur, input logic d);
        state_t nxt;
        case (cur)
            S0:      nxt = d ? S1 : S0;
            S1:      nxt = d ? S2 : S0;
            S2:      nxt = d ? S2 : S3;
            S3:      nxt = d ? S4 : S0;
            S4:      nxt = d ? S2 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    // Round-robin grant: first pending channel at or after rr_ptr, wrapping.
    // It depends only on the holding registers, so bit_valid has no combinational path to bit_ready.
    always_comb begin
        logic [CHW-1:0] idx_v;
        gnt_s     = '0;
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        idx_v     = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_v = CHW'((int'(rr_ptr_r) + k) % NCH);
            if (!gnt_any_s && pend_r[idx_v]) begin
                gnt_any_s        = 1'b1;
                gnt_s[idx_v]     = 1'b1;
                gnt_idx_s        = idx_v;
            end else begin
                gnt_any_s        = gnt_any_s;
            end
        end
    end

    // Shared datapath on the granted channel's context, plus pointer advance.
    always_comb begin
        next_s = next_state(ctx_r[gnt_idx_s], hbit_r[gnt_idx_s]);
        hit_s  = gnt_any_s & (next_s == S4);
        if (gnt_idx_s == CHW'(NCH - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_s + CHW'(1);
        end
    end

    // A granted channel frees its slot this edge, so it can take a new bit
    // at the same time. This lets one busy channel sustain 1 bit/cycle.
    assign bit_ready = ~pend_r | gnt_s;
    assign accept_s  = bit_valid & bit_ready;

    // Holding registers: a new accept overrides the release caused by a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= '0;
            hbit_r <= '0;
        end else begin
            pend_r <= accept_s | (pend_r & ~gnt_s);
            hbit_r <= (accept_s & bit_data) | (~accept_s & hbit_r);
        end
    end

    // Per-channel saved detector state; only the granted channel is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_r[i] <= S0;
            end
        end else if (gnt_any_s) begin
            ctx_r[gnt_idx_s] <= next_s;
        end else begin
            ctx_r[gnt_idx_s] <= ctx_r[gnt_idx_s];
        end
    end

    // Arbiter pointer moves past the served channel; holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (gnt_any_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Registered match pulse; channel index is held between matches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= hit_s;
            if (hit_s) begin
                match_ch <= gnt_idx_s;
            end else begin
                match_ch <= match_ch;
            end
        end
    end

`ifdef SNAIL_MATCH_CNT_EN
    logic [CNTW-1:0] cnt_r [NCH];

    // Saturating per-channel match counters, driven by the registered pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (match_valid && (cnt_r[match_ch] != {CNTW{1'b1}})) begin
            cnt_r[match_ch] <= cnt_r[match_ch] + CNTW'(1);
        end else begin
            cnt_r[match_ch] <= cnt_r[match_ch];
        end
    end

    // Counter read mux; selects beyond the channel count read as zero.
    always_comb begin
        cnt_val = '0;
        if (int'(cnt_sel) < NCH) begin
            cnt_val = cnt_r[cnt_sel];
        end else begin
            cnt_val = '0;
        end
    end
`else
    logic unused_cnt_sel_s;
    assign unused_cnt_sel_s = ^cnt_sel;
    assign cnt_val          = '0;
`endif

endmodule

// File: tb/tb_snail_1101_tdm_sched.sv
// -----------------------------------------------------------------------------
// tb_snail_1101_tdm_sched
//   Self-checking bench for snail_1101_tdm_sched. The reference model keeps,
//   per channel, a holding slot and the last four processed bits. A match is
//   expected whenever those bits read 1101. The model's arbiter picks the first
//   pending channel from its pointer. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snail_1101_tdm_sched;

    localparam int NCH     = 4;
    localparam int CHW     = 2;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  bit_valid = '0;
    logic [NCH-1:0]  bit_data = '0;
    logic [NCH-1:0]  bit_ready;
    logic            match_valid;
    logic [CHW-1:0]  match_ch;
    logic [CHW-1:0]  cnt_sel = '0;
    logic [CNTW-1:0] cnt_val;

    always #5 clk = ~clk;

    snail_1101_tdm_sched #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .bit_ready   (bit_ready),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .cnt_sel     (cnt_sel),
        .cnt_val     (cnt_val)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    bit       pend_m [NCH];
    bit       hbit_m [NCH];
    logic [3:0] hist_m [NCH];
    int       cnt_m  [NCH];
    int       ptr_m;
    bit       exp_mv;
    int       exp_ch;

    bit       q [NCH][$];
    int       wait_c [NCH];
    bit       starve_chk = 1'b0;
    logic [NCH-1:0] acc_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            pend_m[i] = 1'b0;
            hbit_m[i] = 1'b0;
            hist_m[i] = 4'b0000;
            cnt_m[i]  = 0;
            wait_c[i] = 0;
        end
        ptr_m  = 0;
        exp_mv = 1'b0;
        exp_ch = 0;
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = '0;
        cnt_sel   = '0;
        #2;
        model_reset();
        check("rst_match_valid", 32'(match_valid), 32'd0);
        check("rst_match_ch", 32'(match_ch), 32'd0);
        check("rst_bit_ready", 32'(bit_ready), 32'(4'b1111));
        check("rst_cnt_val", 32'(cnt_val), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive, check ready/counter, advance model, check match.
    task automatic tick(input logic [NCH-1:0] v, input logic [NCH-1:0] d,
                        input logic [CHW-1:0] sel, output logic [NCH-1:0] acc);
        int g;
        int cexp;
        logic [NCH-1:0] rdy;
        bit_valid = v;
        bit_data  = d;
        cnt_sel   = sel;
        #1;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            if (g < 0 && pend_m[(ptr_m + k) % NCH]) g = (ptr_m + k) % NCH;
        end
        for (int i = 0; i < NCH; i++) rdy[i] = !pend_m[i] || (g == i);
        check("bit_ready", 32'(bit_ready), 32'(rdy));
`ifdef SNAIL_MATCH_CNT_EN
        cexp = (int'(sel) < NCH) ? cnt_m[sel] : 0;
`else
        cexp = 0;
`endif
        check("cnt_val", 32'(cnt_val), 32'(cexp));
        if (starve_chk) begin
            for (int i = 0; i < NCH; i++) begin
                if (bit_ready[i]) wait_c[i] = 0;
                else wait_c[i]++;
                check("starve", 32'(wait_c[i] < NCH), 32'd1);
            end
        end
        acc = v & rdy;
        @(posedge clk);
        if (exp_mv && cnt_m[exp_ch] < CNT_MAX) cnt_m[exp_ch]++;
        exp_mv = 1'b0;
        if (g >= 0) begin
            hist_m[g] = {hist_m[g][2:0], hbit_m[g]};
            if (hist_m[g] == 4'b1101) begin
                exp_mv = 1'b1;
                exp_ch = g;
            end
            pend_m[g] = 1'b0;
            ptr_m     = (g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (acc[i]) begin
                pend_m[i] = 1'b1;
                hbit_m[i] = d[i];
            end
        end
        #1;
        check("match_valid", 32'(match_valid), 32'(exp_mv));
        check("match_ch", 32'(match_ch), 32'(exp_ch));
    endtask

    task automatic push(input int ch, input string s);
        for (int k = 0; k < s.len(); k++) q[ch].push_back(s[k] == "1");
    endtask

    function automatic int queued();
        int n = 0;
        for (int i = 0; i < NCH; i++) n += q[i].size();
        return n;
    endfunction

    // Present each queue head with valid held until accepted.
    task automatic run_queues(input int budget);
        logic [NCH-1:0] v, d, acc;
        int n = 0;
        while (queued() > 0 && n < budget) begin
            for (int i = 0; i < NCH; i++) begin
                v[i] = q[i].size() > 0;
                d[i] = v[i] ? q[i][0] : 1'b0;
            end
            tick(v, d, CHW'($urandom), acc);
            for (int i = 0; i < NCH; i++) if (acc[i]) void'(q[i].pop_front());
            n++;
        end
        check("queues_drained", 32'(queued()), 32'd0);
        for (int i = 0; i < NCH; i++) q[i].delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0, '0, CHW'($urandom), acc_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // ch0 only, 1101 then 1 (overlap continues into S2)
        push(0, "11011");
        run_queues(20);
        idle(3);

        // overlapping double match, then 1100 1101 with single match
        push(0, "1101101");
        run_queues(20);
        idle(3);
        push(0, "11001101");
        run_queues(20);
        idle(3);

        // all channels loaded; only ch2 carries the pattern
        do_reset();
        starve_chk = 1'b1;
        push(0, "00000000");
        push(1, "00000000");
        push(2, "11010000");
        push(3, "00000000");
        run_queues(60);
        starve_chk = 1'b0;
        idle(4);

        // ch1 and ch3 interleaved, ch3 one bit behind
        tick(4'b0010, 4'b0010, '0, acc_d);
        push(1, "101");
        push(3, "1101");
        run_queues(30);
        idle(4);

        // reset after 110 leaves a pending bit; both state and slot are discarded
        push(0, "110");
        run_queues(20);
        do_reset();
        push(0, "1");
        run_queues(10);
        idle(3);
        push(0, "101");
        run_queues(10);
        idle(3);

        // five matches on ch0 against a 2-bit counter
        do_reset();
        push(0, "1101101101101101");
        run_queues(60);
        idle(3);
        tick('0, '0, CHW'(0), acc_d);
        tick('0, '0, CHW'(1), acc_d);

        // random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            tick(NCH'($urandom), NCH'($urandom), CHW'($urandom), acc_d);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
